// File: rtl/mem_req_sequencer.sv
// Vector memory request sequencer: expands a strided load/store command
// into per-beat queue requests and waits for queue completion.
module mem_req_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int LEN_BITS       = 9,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_is_store,
    input  logic [ADDR_WIDTH-1:0]   cmd_base,
    input  logic [ADDR_WIDTH-1:0]   cmd_stride,
    input  logic [LEN_BITS-1:0]     cmd_len,
    input  logic [DATA_WIDTH-1:0]   st_data,
    input  logic                    st_valid,
    output logic                    st_ready,
    output logic [ADDR_WIDTH-1:0]   q_addr_out,
    output logic [DATA_WIDTH-1:0]   q_data_out,
    output logic                    q_req_out,
    output logic                    q_valid_out,
    output logic                    q_start_out,
    output logic [DATA_WIDTH/8-1:0] q_be_out,
    output logic                    q_ready_out,
    input  logic                    q_done_ld,
    input  logic                    q_done_st,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WMAX = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE, ST_WAIT, FIN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] stride;
    logic [LEN_BITS-1:0]   len;
    logic [LEN_BITS-1:0]   idx;
    logic [WW-1:0]         wcnt;
    logic                  to_flag;
    logic                  last;

    assign last        = (idx == len - LEN_BITS'(1));
    assign cmd_ready   = (state == IDLE);
    assign st_ready    = (state == ST_ISSUE);
    assign busy        = (state != IDLE);
    assign q_ready_out = (state == LD_ISSUE) || (state == LD_WAIT);
    assign q_be_out    = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            stride      <= '0;
            len         <= '0;
            idx         <= '0;
            wcnt        <= '0;
            to_flag     <= 1'b0;
            q_addr_out  <= '0;
            q_data_out  <= '0;
            q_req_out   <= 1'b0;
            q_valid_out <= 1'b0;
            q_start_out <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            q_req_out   <= 1'b0;
            q_valid_out <= 1'b0;
            q_start_out <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr    <= cmd_base;
                        stride  <= cmd_stride;
                        len     <= cmd_len;
                        idx     <= '0;
                        to_flag <= 1'b0;
                        if (cmd_len == '0)
                            state <= FIN;
                        else if (cmd_is_store)
                            state <= ST_ISSUE;
                        else
                            state <= LD_ISSUE;
                    end
                end
                LD_ISSUE: begin
                    q_req_out  <= 1'b1;
                    q_addr_out <= addr;
                    addr       <= addr + stride;
                    idx        <= idx + LEN_BITS'(1);
                    if (last) begin
                        state <= LD_WAIT;
                        wcnt  <= '0;
                    end
                end
                ST_ISSUE: begin
                    // Stall without advancing when no store beat is offered
                    if (st_valid) begin
                        q_valid_out <= 1'b1;
                        q_data_out  <= st_data;
                        q_addr_out  <= addr;
                        q_start_out <= (idx == '0);
                        addr        <= addr + stride;
                        idx         <= idx + LEN_BITS'(1);
                        if (last) begin
                            state <= ST_WAIT;
                            wcnt  <= '0;
                        end
                    end
                end
                LD_WAIT, ST_WAIT: begin
                    if ((state == LD_WAIT) ? q_done_ld : q_done_st) begin
                        state <= FIN;
                    end else if (wcnt == WMAX) begin
                        state   <= FIN;
                        to_flag <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    err   <= to_flag;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_req_sequencer.md
MEM_REQ_SEQUENCER -- requirements
Module: mem_req_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, 32, address width.
REQ-002 Parameter DATA_WIDTH, 64, vector beat width.
REQ-003 Parameter LEN_BITS, 9, beat-count width; max burst 2^LEN_BITS-1 beats.
REQ-004 Parameter TIMEOUT_CYCLES, 1023, maximum wait for queue completion.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cmd_valid  in  1  vector memory command offered.
REQ-008 cmd_ready  out  1  sequencer accepts a command.
REQ-009 cmd_is_store  in  1  1=store, 0=load.
REQ-010 cmd_base  in  ADDR_WIDTH  first beat address.
REQ-011 cmd_stride  in  ADDR_WIDTH  byte step between beats.
REQ-012 cmd_len  in  LEN_BITS  beat count.
REQ-013 st_data  in  DATA_WIDTH  store beat data.
REQ-014 st_valid  in  1  store beat available.
REQ-015 st_ready  out  1  store beat consumed.
REQ-016 q_addr_out  out  ADDR_WIDTH  beat address to memory queue.
REQ-017 q_data_out  out  DATA_WIDTH  store data to memory queue.
REQ-018 q_req_out  out  1  load request strobe, one per beat.
REQ-019 q_valid_out  out  1  store beat strobe.
REQ-020 q_start_out  out  1  first store beat marker.
REQ-021 q_be_out  out  DATA_WIDTH/8  byte enables, all ones.
REQ-022 q_ready_out  out  1  sequencer ready for load return data.
REQ-023 q_done_ld, q_done_st  in  1 each  queue completion pulses.
REQ-024 busy  out  1  command in progress.
REQ-025 done  out  1  one-cycle completion pulse.
REQ-026 err  out  1  one-cycle timeout pulse, coincident with done.

Function
REQ-027 FSM states IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE, ST_WAIT, FIN, encoded in one register.
REQ-028 cmd_ready = 1 only in IDLE; command captured on cmd_valid & cmd_ready.
REQ-029 On capture: len != 0 -> LD_ISSUE or ST_ISSUE per cmd_is_store; len == 0 -> FIN, no queue traffic.
REQ-030 Beat address = cmd_base + i*cmd_stride, i = 0..len-1, computed by running accumulator, modulo 2^ADDR_WIDTH (wrap, no error).
REQ-031 LD_ISSUE: q_req_out = 1 every cycle, one beat per cycle, q_addr_out = beat i address; after beat len-1 -> LD_WAIT.
REQ-032 ST_ISSUE: st_ready = 1; beat issued only when st_valid; issuing cycle drives q_valid_out = 1, q_data_out = st_data, q_addr_out = beat address; q_start_out = 1 on beat 0 only.
REQ-033 ST_ISSUE with st_valid = 0: q_valid_out = 0, beat index and address hold.
REQ-034 After store beat len-1 -> ST_WAIT.
REQ-035 q_ready_out = 1 in LD_ISSUE and LD_WAIT, else 0.
REQ-036 LD_WAIT exits to FIN on q_done_ld; ST_WAIT exits to FIN on q_done_st.
REQ-037 q_done_ld/q_done_st outside the matching WAIT state ignored.
REQ-038 Wait counter clears on WAIT entry, increments each WAIT cycle; reaching TIMEOUT_CYCLES -> FIN with err.
REQ-039 Done and timeout in same cycle: done wins, err = 0.
REQ-040 FIN: done = 1 for one cycle, next state IDLE; new command accepted no earlier than IDLE cycle.
REQ-041 busy = 1 in every state except IDLE.
REQ-042 All q_* strobes registered: one-cycle latency from FSM decision to port.

Reset
REQ-043 rst_n low forces IDLE immediately, regardless of current state.
REQ-044 Reset values: cmd_ready 1 after release, all strobes, busy, done, err, st_ready 0; q_addr_out, q_data_out 0; counters 0.
REQ-045 Reset mid-burst abandons remaining beats; no further q_* strobes after rst_n deassertion until new command.

Verification
REQ-046 Load base 0x1000, stride 8, len 4, q_done_ld 5 cycles later -> q_req_out 4 consecutive cycles, addresses 0x1000/08/10/18, done 1 cycle, err 0.
REQ-047 Store len 3, st_valid toggling 1,0,1,1 -> exactly 3 q_valid_out beats, q_start_out only on first, data matches in order.
REQ-048 Load base 0xFFFFFFF8, stride 8, len 2 -> addresses 0xFFFFFFF8, 0x00000000.
REQ-049 len 0 command -> no q_req_out/q_valid_out, done 2 cycles after acceptance.
REQ-050 No q_done_st after store -> err and done at TIMEOUT_CYCLES, then cmd_ready 1.
REQ-051 rst_n asserted during LD_ISSUE beat 2 of 8 -> strobes 0 asynchronously, IDLE, no later requests.
